// File: rtl/pe_dmem_arbiter_pkg.sv
// pe_dmem_arbiter_pkg: shared PE data-memory arbitration definitions.
//   - Default widths and limits for the PE DMEM arbiter.
//   - Arbiter state encodings (ARB_PE, ARB_DMA).
//   - Read-return owner encodings (none, PE, DMA).
// Optional feature macro used by importers: PE_DMEM_ARB_BURST_EN.
package pe_dmem_arbiter_pkg;

  localparam int unsigned DEF_PE_DATA_WIDTH = 32;
  localparam int unsigned DEF_STARVE_LIMIT  = 8;
  localparam int unsigned DEF_CNT_WIDTH     = 4;
  localparam int unsigned DEF_BURST_LEN     = 4;

  typedef enum logic {
    ARB_PE  = 1'b0,
    ARB_DMA = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_PE   = 2'd1,
    RD_DMA  = 2'd2
  } rd_owner_t;

endpackage

// File: rtl/pe_dmem_starve_cnt.sv
// pe_dmem_starve_cnt: saturating starvation counter with threshold compare.
// Ports:
//   clk    in   clock, positive edge
//   reset  in   synchronous active-high reset
//   inc    in   a pending request lost arbitration this cycle
//   clr    in   request served or withdrawn; clear has priority over inc
//   hit    out  this cycle's increment reaches STARVE_LIMIT
module pe_dmem_starve_cnt #(
  parameter int unsigned CNT_WIDTH    = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_inc;

  always_comb begin
    cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    // Compare the post-increment value so the forced slot follows the
    // STARVE_LIMIT-th denial directly.
    hit     = inc && (cnt_inc >= LIMIT);
  end

  always_ff @(posedge clk) begin
    if (reset)    cnt_q <= '0;
    else if (clr) cnt_q <= '0;
    else if (inc) cnt_q <= cnt_inc;
  end

endmodule

// File: rtl/pe_dmem_arbiter.sv
// pe_dmem_arbiter: shares the single-port PE data memory between the PE
// load/store path (AGU) and the DMA/host port.
//   - PE has priority; a starving DMA request is forced one slot (PE stalled).
//   - Read-return owner is registered so one-cycle read data goes back to
//     the requester that issued the read.
// Ports:
//   iClk, iReset                  clock, synchronous active-high reset
//   iAGU_*                        PE load/store request (pass-through)
//   oPE_Stall, oPE_Read_Data      PE stall and load return
//   iDMA_*                        DMA request, word address, write data
//   oDMA_Grant, oDMA_Read_*       DMA accept and read return
//   oDMEM_*, iDMEM_Read_Data      memory macro interface
// Optional macro PE_DMEM_ARB_BURST_EN: the forced DMA slot becomes a burst
// of up to BURST_LEN consecutive grants while iDMA_Req stays high.
module pe_dmem_arbiter
  import pe_dmem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEF_PE_DATA_WIDTH,
  parameter int unsigned STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int unsigned CNT_WIDTH    = DEF_CNT_WIDTH,
  parameter int unsigned BURST_LEN    = DEF_BURST_LEN
) (
  input  logic                    iClk,
  input  logic                    iReset,
  input  logic                    iAGU_Write_Enable,
  input  logic                    iAGU_Read_Enable,
  input  logic [DATA_WIDTH/8-1:0] iAGU_Byte_Select,
  input  logic [DATA_WIDTH-1:0]   iAGU_Address,
  input  logic [DATA_WIDTH-1:0]   iAGU_Store_Data,
  output logic                    oPE_Stall,
  output logic [DATA_WIDTH-1:0]   oPE_Read_Data,
  input  logic                    iDMA_Req,
  input  logic                    iDMA_Write,
  input  logic [DATA_WIDTH-1:0]   iDMA_Address,
  input  logic [DATA_WIDTH-1:0]   iDMA_Data,
  output logic                    oDMA_Grant,
  output logic                    oDMA_Read_Valid,
  output logic [DATA_WIDTH-1:0]   oDMA_Read_Data,
  output logic                    oDMEM_Enable,
  output logic                    oDMEM_Write_Enable,
  output logic [DATA_WIDTH/8-1:0] oDMEM_Byte_Select,
  output logic [DATA_WIDTH-1:0]   oDMEM_Address,
  output logic [DATA_WIDTH-1:0]   oDMEM_Write_Data,
  input  logic [DATA_WIDTH-1:0]   iDMEM_Read_Data
);

  arb_state_t state_q, state_d;
  rd_owner_t  owner_q, owner_d;

  logic pe_req;
  logic pe_access;
  logic dma_grant;
  logic stall;
  logic starve_inc;
  logic starve_clr;
  logic starve_hit;
  logic burst_last;

  // Word-aligned DMA address: the low two bits never reach the memory.
  logic unused_dma_addr_lsb;
  assign unused_dma_addr_lsb = ^iDMA_Address[1:0];

  assign pe_req = iAGU_Write_Enable | iAGU_Read_Enable;

  pe_dmem_starve_cnt #(
    .CNT_WIDTH   (CNT_WIDTH),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve_cnt (
    .clk  (iClk),
    .reset(iReset),
    .inc  (starve_inc),
    .clr  (starve_clr),
    .hit  (starve_hit)
  );

  assign starve_inc = (state_q == ARB_PE) && pe_req && iDMA_Req && !iReset;
  assign starve_clr = dma_grant || !iDMA_Req;

`ifdef PE_DMEM_ARB_BURST_EN
  logic [CNT_WIDTH-1:0] burst_q;

  assign burst_last = (burst_q == CNT_WIDTH'(BURST_LEN - 1));

  always_ff @(posedge iClk) begin
    if (iReset || state_d != ARB_DMA) burst_q <= '0;
    else if (dma_grant)               burst_q <= burst_q + 1'b1;
  end
`else
  // Single forced slot: every DMA-state grant is the last one.
  assign burst_last = 1'b1;
  logic unused_burst_len;
  assign unused_burst_len = (BURST_LEN == 0);
`endif

  always_comb begin
    state_d   = state_q;
    dma_grant = 1'b0;
    stall     = 1'b0;
    pe_access = 1'b0;
    // Arbitration is held off during reset so every output sits at its
    // reset value in the reset cycle.
    if (!iReset) begin
      case (state_q)
        ARB_PE: begin
          if (pe_req) begin
            pe_access = 1'b1;
            if (starve_hit) state_d = ARB_DMA;
          end else if (iDMA_Req) begin
            dma_grant = 1'b1;
          end
        end
        ARB_DMA: begin
          state_d = ARB_PE;
          if (iDMA_Req) begin
            dma_grant = 1'b1;
            stall     = pe_req;
            if (!burst_last) state_d = ARB_DMA;
          end else begin
            pe_access = pe_req;
          end
        end
        default: state_d = ARB_PE;
      endcase
    end
  end

  always_comb begin
    owner_d = RD_NONE;
    if (dma_grant && !iDMA_Write)                owner_d = RD_DMA;
    else if (pe_access && !iAGU_Write_Enable)    owner_d = RD_PE;
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q <= ARB_PE;
      owner_q <= RD_NONE;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    oDMA_Grant         = dma_grant;
    oPE_Stall          = stall;
    oDMEM_Enable       = dma_grant | pe_access;
    // Store wins over load: any asserted AGU write makes the access a write.
    oDMEM_Write_Enable = dma_grant ? iDMA_Write : (pe_access & iAGU_Write_Enable);
    oDMEM_Byte_Select  = dma_grant ? '1 : iAGU_Byte_Select;
    oDMEM_Address      = dma_grant ? {iDMA_Address[DATA_WIDTH-1:2], 2'b00} : iAGU_Address;
    oDMEM_Write_Data   = dma_grant ? iDMA_Data : iAGU_Store_Data;
  end

  // Return gated by reset too: a read granted just before reset never
  // produces a valid.
  always_comb begin
    oDMA_Read_Valid = (owner_q == RD_DMA) && !iReset;
    oDMA_Read_Data  = oDMA_Read_Valid ? iDMEM_Read_Data : '0;
    oPE_Read_Data   = ((owner_q == RD_PE) && !iReset) ? iDMEM_Read_Data : '0;
  end

endmodule

// File: tb/tb_pe_dmem_arbiter.sv
// tb_pe_dmem_arbiter: directed scoreboard bench for pe_dmem_arbiter.
// Stimulus pushes the hand-derived expected outputs of each cycle into a
// queue; a monitor on the falling edge pops and compares them.
module tb_pe_dmem_arbiter;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          agu_we = 1'b0, agu_re = 1'b0;
  logic [3:0]    agu_bs = '0;
  logic [DW-1:0] agu_addr = '0, agu_wd = '0;
  logic          pe_stall;
  logic [DW-1:0] pe_rd;
  logic          dma_req = 1'b0, dma_wr = 1'b0;
  logic [DW-1:0] dma_addr = '0, dma_data = '0;
  logic          dma_grant, dma_rv;
  logic [DW-1:0] dma_rd;
  logic          mem_en, mem_we;
  logic [3:0]    mem_bs;
  logic [DW-1:0] mem_addr, mem_wd;
  logic [DW-1:0] mem_rd = '0;

  always #5 clk = ~clk;

  pe_dmem_arbiter #(
    .DATA_WIDTH  (32),
    .STARVE_LIMIT(8),
    .CNT_WIDTH   (4),
    .BURST_LEN   (4)
  ) dut (
    .iClk              (clk),
    .iReset            (rst),
    .iAGU_Write_Enable (agu_we),
    .iAGU_Read_Enable  (agu_re),
    .iAGU_Byte_Select  (agu_bs),
    .iAGU_Address      (agu_addr),
    .iAGU_Store_Data   (agu_wd),
    .oPE_Stall         (pe_stall),
    .oPE_Read_Data     (pe_rd),
    .iDMA_Req          (dma_req),
    .iDMA_Write        (dma_wr),
    .iDMA_Address      (dma_addr),
    .iDMA_Data         (dma_data),
    .oDMA_Grant        (dma_grant),
    .oDMA_Read_Valid   (dma_rv),
    .oDMA_Read_Data    (dma_rd),
    .oDMEM_Enable      (mem_en),
    .oDMEM_Write_Enable(mem_we),
    .oDMEM_Byte_Select (mem_bs),
    .oDMEM_Address     (mem_addr),
    .oDMEM_Write_Data  (mem_wd),
    .iDMEM_Read_Data   (mem_rd)
  );

  // Single-port memory macro, one-cycle read latency.
  logic [DW-1:0] mem [0:255];
  initial for (int i = 0; i < 256; i++) mem[i] = '0;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_bs[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_wd[8*b +: 8];
      end else begin
        mem_rd <= mem[mem_addr[9:2]];
      end
    end
  end

  typedef struct {
    string         name;
    logic          g, s, en, we;
    logic [3:0]    bs;
    logic [DW-1:0] addr, wd;
    logic          rv;
    logic [DW-1:0] drd, prd;
  } exp_t;

  exp_t q[$];
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input string f, input logic [DW-1:0] act, input logic [DW-1:0] exv);
    n_chk++;
    if (act !== exv) begin
      n_fail++;
      $display("FAIL %s.%s: got %h expected %h at %0t", nm, f, act, exv, $time);
    end
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin : mon
      exp_t e;
      e = q.pop_front();
      chk(e.name, "grant", 32'(dma_grant), 32'(e.g));
      chk(e.name, "stall", 32'(pe_stall), 32'(e.s));
      chk(e.name, "dmem_en", 32'(mem_en), 32'(e.en));
      chk(e.name, "dmem_we", 32'(mem_we), 32'(e.we));
      if (e.en) begin
        chk(e.name, "dmem_bs", 32'(mem_bs), 32'(e.bs));
        chk(e.name, "dmem_addr", mem_addr, e.addr);
      end
      if (e.en && e.we) chk(e.name, "dmem_wd", mem_wd, e.wd);
      chk(e.name, "dma_rv", 32'(dma_rv), 32'(e.rv));
      chk(e.name, "dma_rd", dma_rd, e.drd);
      chk(e.name, "pe_rd", pe_rd, e.prd);
    end
  end

  task automatic drive(input logic rs, input logic awe, input logic are, input logic [3:0] abs,
                       input logic [DW-1:0] aad, input logic [DW-1:0] awd,
                       input logic dreq, input logic dwr, input logic [DW-1:0] dad, input logic [DW-1:0] ddat);
    rst = rs; agu_we = awe; agu_re = are; agu_bs = abs; agu_addr = aad; agu_wd = awd;
    dma_req = dreq; dma_wr = dwr; dma_addr = dad; dma_data = ddat;
  endtask

  task automatic expect_v(input string nm, input logic g, input logic s, input logic en, input logic we,
                          input logic [3:0] bs, input logic [DW-1:0] addr, input logic [DW-1:0] wd,
                          input logic rv, input logic [DW-1:0] drd, input logic [DW-1:0] prd);
    exp_t e;
    e.name = nm; e.g = g; e.s = s; e.en = en; e.we = we; e.bs = bs;
    e.addr = addr; e.wd = wd; e.rv = rv; e.drd = drd; e.prd = prd;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [DW-1:0] BEEF = 32'hDEADBEEF;
  localparam logic [DW-1:0] W80  = 32'h1122AA44;

  // PE load of 0x80 with an optional DMA read request of 0x40.
  task automatic pe_load(input logic dreq);
    drive(0, 0, 1, 4'hF, 32'h80, 32'h0, dreq, 0, 32'h40, 32'h0);
  endtask

  task automatic idle();
    drive(0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
  endtask

  initial begin
    step();
    // Reset state.
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
      expect_v("reset", 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0); step();
    end
    // DMA write then read with PE idle.
    drive(0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 1, 32'h40, BEEF);
    expect_v("dma_wr", 1, 0, 1, 1, 4'hF, 32'h40, BEEF, 0, 0, 0); step();
    drive(0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h42, 32'h0);
    expect_v("dma_rd", 1, 0, 1, 0, 4'hF, 32'h40, 0, 0, 0, 0); step();
    idle();
    expect_v("dma_ret", 0, 0, 0, 0, 4'h0, 0, 0, 1, BEEF, 0); step();
    // PE stores pass through, including a partial byte store.
    drive(0, 1, 0, 4'hF, 32'h80, 32'h11223344, 0, 0, 32'h0, 32'h0);
    expect_v("pe_st", 0, 0, 1, 1, 4'hF, 32'h80, 32'h11223344, 0, 0, 0); step();
    drive(0, 1, 0, 4'h2, 32'h81, 32'h0000AA00, 0, 0, 32'h0, 32'h0);
    expect_v("pe_st_b", 0, 0, 1, 1, 4'h2, 32'h81, 32'h0000AA00, 0, 0, 0); step();
    // Alternating PE and DMA reads: each return goes to its issuer only.
    pe_load(0);
    expect_v("alt_pe0", 0, 0, 1, 0, 4'hF, 32'h80, 0, 0, 0, 0); step();
    drive(0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h40, 32'h0);
    expect_v("alt_dma", 1, 0, 1, 0, 4'hF, 32'h40, 0, 0, 0, W80); step();
    pe_load(0);
    expect_v("alt_pe1", 0, 0, 1, 0, 4'hF, 32'h80, 0, 1, BEEF, 0); step();
    idle();
    expect_v("alt_ret", 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, W80); step();
    // Store and load together: store wins, no read return follows.
    drive(0, 1, 1, 4'hF, 32'h84, 32'h55, 0, 0, 32'h0, 32'h0);
    expect_v("st_ld", 0, 0, 1, 1, 4'hF, 32'h84, 32'h55, 0, 0, 0); step();
    idle();
    expect_v("st_ld_ret", 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0); step();
    // DMA request drops during the wait; the counter restarts.
    for (int i = 0; i < 5; i++) begin
      pe_load(1);
      expect_v("wait_a", 0, 0, 1, 0, 4'hF, 32'h80, 0, 0, 0, (i == 0) ? 32'h0 : W80); step();
    end
    pe_load(0);
    expect_v("drop_a", 0, 0, 1, 0, 4'hF, 32'h80, 0, 0, 0, W80); step();
    for (int i = 0; i < 8; i++) begin
      pe_load(1);
      expect_v("wait_b", 0, 0, 1, 0, 4'hF, 32'h80, 0, 0, 0, W80); step();
    end
    // Request withdrawn exactly at the forced slot: no grant, no stall.
    pe_load(0);
    expect_v("drop_slot", 0, 0, 1, 0, 4'hF, 32'h80, 0, 0, 0, W80); step();
    // Continuous contention: 8 denials, forced grant with stall on the 9th.
    for (int i = 0; i < 8; i++) begin
      pe_load(1);
      expect_v("starve", 0, 0, 1, 0, 4'hF, 32'h80, 0, 0, 0, W80); step();
    end
    pe_load(1);
    expect_v("forced", 1, 1, 1, 0, 4'hF, 32'h40, 0, 0, 0, W80); step();
`ifdef PE_DMEM_ARB_BURST_EN
    pe_load(0);
`else
    pe_load(1);
`endif
    expect_v("pe_resume", 0, 0, 1, 0, 4'hF, 32'h80, 0, 1, BEEF, 0); step();
    idle();
    expect_v("resume_ret", 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, W80); step();
    // Reset the cycle after a DMA read grant: the return is dropped.
    drive(0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h40, 32'h0);
    expect_v("rst_rd", 1, 0, 1, 0, 4'hF, 32'h40, 0, 0, 0, 0); step();
    drive(1, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    expect_v("rst_mid", 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0); step();
    idle();
    expect_v("rst_after", 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 0); step();
`ifdef PE_DMEM_ARB_BURST_EN
    // Burst: 4 back-to-back DMA grants with the PE stalled, then PE resumes.
    for (int i = 0; i < 8; i++) begin
      pe_load(1);
      expect_v("b_starve", 0, 0, 1, 0, 4'hF, 32'h80, 0, 0, 0, (i == 0) ? 32'h0 : W80); step();
    end
    for (int i = 0; i < 4; i++) begin
      pe_load(1);
      expect_v("burst", 1, 1, 1, 0, 4'hF, 32'h40, 0, (i != 0), (i != 0) ? BEEF : 32'h0,
               (i == 0) ? W80 : 32'h0); step();
    end
    pe_load(1);
    expect_v("b_resume", 0, 0, 1, 0, 4'hF, 32'h80, 0, 1, BEEF, 0); step();
    idle();
    expect_v("b_ret", 0, 0, 0, 0, 4'h0, 0, 0, 0, 0, W80); step();
`endif
    repeat (2) @(posedge clk);
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
